// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: receiver states and line-level constants shared with the PISO-side framer.
package sipo_rx_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: right-shifting SIPO register, new bit enters at the MSB.
module sipo_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (en) q <= {din, q[DATA_W-1:1]};
endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: start/stop framed serial receiver with a one-entry valid/ready holding register.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bit_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  rx_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] sr;
  logic start, shift, last, commit, bad_stop;
  always_comb begin
    start    = bit_en && state == RX_IDLE && serial_in == START_BIT;
    shift    = bit_en && state == RX_DATA;
    last     = cnt == CW'(DATA_W - 1);
    commit   = bit_en && state == RX_STOP && serial_in == STOP_BIT;
    bad_stop = bit_en && state == RX_STOP && serial_in != STOP_BIT;
    state_nx = state;
    case (state)
      RX_IDLE: state_nx = start ? RX_DATA : RX_IDLE;
      RX_DATA: state_nx = (shift && last) ? RX_STOP : RX_DATA;
      RX_STOP: state_nx = bit_en ? RX_IDLE : RX_STOP;
      default: state_nx = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= RX_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (!reset_n || start) cnt <= '0;
    else if (shift) cnt <= cnt + 1'b1;
  sipo_shift_reg #(.DATA_W(DATA_W)) u_sr (
    .clk (clk),
    .clr (!reset_n),
    .en  (shift),
    .din (serial_in),
    .q   (sr)
  );
  // A commit into a full holding register only lands if the old word is read on the same edge.
  always_ff @(posedge clk)
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      if (commit && (!data_valid || data_ready)) begin
        data_out   <= sr;
        data_valid <= 1'b1;
      end else begin
        if (commit) overrun <= 1'b1;
        if (data_valid && data_ready) data_valid <= 1'b0;
      end
    end
  assign busy = state != RX_IDLE;
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed frame tests for sipo_rx with hand-computed expectations.
module tb_sipo_rx;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       serial_in = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun, busy;
  int checks = 0;
  int errors = 0;

  sipo_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bit_en     (bit_en),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic put_bit(input logic b);
    bit_en = 1'b1;
    serial_in = b;
    @(negedge clk);
    bit_en = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      serial_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    serial_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap, input logic rdy_stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) data_ready = rdy_stop;
      put_bit(f[i]);
      if (i < 9) idle(gap);
    end
  endtask

  initial begin
    logic [9:0] line;
    do_reset();
    chk("reset_valid", 32'(data_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    line = 10'b1101001010;
    for (int i = 0; i < 10; i++) put_bit(line[i]);
    chk("t2_data", 32'(data_out), 32'hA5);
    chk("t2_valid", 32'(data_valid), 32'd1);
    chk("t2_ferr", 32'(frame_err), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b1);
    chk("t1_busy_mid", 32'(busy), 32'd1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_rst_data", 32'(data_out), 32'h0);
    chk("t1_rst_valid", 32'(data_valid), 32'd0);
    chk("t1_rst_busy", 32'(busy), 32'd0);
    chk("t1_rst_ferr", 32'(frame_err), 32'd0);
    chk("t1_rst_ovr", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    chk("t1_data", 32'(data_out), 32'hA5);
    chk("t1_valid", 32'(data_valid), 32'd1);

    do_reset();
    send_frame(8'h3C, 1'b1, 2, 1'b0);
    chk("t3_data", 32'(data_out), 32'h3C);
    chk("t3_valid", 32'(data_valid), 32'd1);
    chk("t3_ferr", 32'(frame_err), 32'd0);

    do_reset();
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    chk("t4_ferr", 32'(frame_err), 32'd1);
    chk("t4_valid", 32'(data_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_ferr_pulse", 32'(frame_err), 32'd0);
    chk("t4_busy_after", 32'(busy), 32'd0);

    do_reset();
    send_frame(8'h11, 1'b1, 0, 1'b0);
    chk("t5_first_ovr", 32'(overrun), 32'd0);
    send_frame(8'h22, 1'b1, 0, 1'b0);
    chk("t5_data", 32'(data_out), 32'h11);
    chk("t5_valid", 32'(data_valid), 32'd1);
    chk("t5_ovr", 32'(overrun), 32'd1);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("t5_drop", 32'(data_valid), 32'd0);
    chk("t5_ovr_sticky", 32'(overrun), 32'd1);

    do_reset();
    send_frame(8'h11, 1'b1, 0, 1'b0);
    chk("t6_held", 32'(data_out), 32'h11);
    send_frame(8'h22, 1'b1, 0, 1'b1);
    data_ready = 1'b0;
    chk("t6_data", 32'(data_out), 32'h22);
    chk("t6_valid", 32'(data_valid), 32'd1);
    chk("t6_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    chk("t6_valid_hold", 32'(data_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
